div: RTL and testbench
======================

DIV -- requirements
Module: div

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (rst=0 resets).
REQ-003 SHALL have port signed_div_i, input, 1 bit: 1 = DIV (two's-complement), 0 = DIVU.
REQ-004 SHALL have port opdata1_i, input, 32 bits: dividend.
REQ-005 SHALL have port opdata2_i, input, 32 bits: divisor.
REQ-006 SHALL have port start_i, input, 1 bit: request from EX; held high until EX consumes the result.
REQ-007 SHALL have port annul_i, input, 1 bit: cancel the in-flight division (flush).
REQ-008 SHALL have port result_o, output, 64 bits: {remainder[63:32] -> HI, quotient[31:0] -> LO}.
REQ-009 SHALL have port ready_o, output, 1 bit: result_o is valid.

Function
REQ-010 SHALL implement a four-state FSM: FREE, BYZERO, ON, END.
REQ-011 SHALL drive result_o and ready_o only from registers, with no combinational path from inputs.
REQ-012 In FREE with start_i=1 and annul_i=0: if opdata2_i==0, go to BYZERO; else go to ON with cnt=0 and operands latched.
REQ-013 In FREE with start_i=0 or annul_i=1: stay in FREE, ready_o=0, result_o=0.
REQ-014 Operands SHALL be latched at the start edge; input changes afterwards SHALL NOT affect the result.
REQ-015 When signed_div_i=1, latch |opdata1_i| and |opdata2_i|; when 0, latch the operands unchanged.
REQ-016 In ON, while cnt<32: perform one radix-2 restoring step per cycle (shift 65-bit partial remainder/quotient, trial-subtract 33-bit divisor, set quotient bit on non-negative result) and increment cnt.
REQ-017 In ON with cnt==32: apply the sign correction and go to END with ready_o=1.
REQ-018 Signed correction: negate the quotient when the operand signs differ; give the remainder the sign of the dividend.
REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0; no exception.
REQ-020 From BYZERO, go to END at the next edge with result_o=0 and ready_o=1.
REQ-021 In END: hold result_o and ready_o=1 while start_i=1; when start_i=0, go to FREE, clearing ready_o and result_o at that edge.
REQ-022 annul_i=1 in ON or BYZERO SHALL return the FSM to FREE at the next edge, with ready_o=0 and result_o=0.
REQ-023 annul_i SHALL be ignored in END.
REQ-024 Latency: with start sampled at edge N, ready_o SHALL rise after edge N+33 for a nonzero divisor and after edge N+1 for a zero divisor.
REQ-025 Only one division SHALL be in flight; start_i is not re-sampled until the FSM is back in FREE.

Reset
REQ-026 rst=0 SHALL immediately (asynchronously) force state=FREE, cnt=0, ready_o=0, result_o=0, and all datapath registers to 0, including mid-division.
REQ-027 After rst deasserts, the first start_i sampled in FREE SHALL begin a fresh division.

Verification
REQ-028 Unsigned: opdata1_i=100, opdata2_i=7, signed_div_i=0, start at edge N -> ready_o=1 after N+33, result_o={32'd2, 32'd14}.
REQ-029 Signed: 0xFFFFFFF9 (-7) / 2 -> result_o={0xFFFFFFFF, 0xFFFFFFFD}; 7 / 0xFFFFFFFE (-2) -> {0x00000001, 0xFFFFFFFD}.
REQ-030 Divide by zero: 5 / 0 -> ready_o=1 after N+1, result_o=0; with start_i dropped, ready_o=0 at the next edge.
REQ-031 Annul: annul_i=1 for one cycle at cnt=10 -> FSM in FREE, ready_o stays 0; a new start (9/3) then gives {0, 3} after 33 edges.
REQ-032 Reset mid-run: rst=0 at cnt=20 -> ready_o=0 and result_o=0 without a clock edge; a restarted 0xFFFFFFFF/1 unsigned gives {0, 0xFFFFFFFF}.
REQ-033 Handshake hold: keep start_i=1 for 5 cycles in END -> result_o stable and ready_o=1; operand changes during ON do not alter the result.

Source files
------------

// File: rtl/div.sv
// -----------------------------------------------------------------------------
// div: iterative 32-bit integer divider (signed DIV / unsigned DIVU).
//
// A radix-2 restoring divider that retires one quotient bit per cycle. Signed
// operands are converted to magnitudes when the request is accepted. The
// signs are applied again after the 32nd step.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst          asynchronous active-low reset
//   signed_div_i 1 = two's-complement divide, 0 = unsigned divide
//   opdata1_i    dividend
//   opdata2_i    divisor
//   start_i      request; held high until the result has been consumed
//   annul_i      flush the division in flight (ignored once a result is ready)
//   result_o     {remainder, quotient}; zero unless ready_o is high
//   ready_o      result_o is valid
//
// Handshake: a request is accepted only in StFree. A nonzero divisor gives the
// result 33 edges after the accepting edge. A zero divisor gives an all-zero
// result one edge after it. The result is held until start_i drops.
// -----------------------------------------------------------------------------
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        StFree,
        StByZero,
        StOn,
        StEnd
    } state_e;

    localparam logic [5:0] NumSteps = 6'd32;

    state_e      state_q,    state_d;
    logic [5:0]  cnt_q,      cnt_d;
    // work_q[63:32] holds the partial remainder. work_q[31:0] holds the
    // dividend bits that have not been consumed, with the quotient bits
    // shifted in behind them.
    logic [64:0] work_q,     work_d;
    logic [31:0] divisor_q,  divisor_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q,  neg_rem_d;
    logic [63:0] result_q,   result_d;
    logic        ready_q,    ready_d;

    // Operand magnitudes for the request currently on the inputs.
    logic [31:0] op1_mag;
    logic [31:0] op2_mag;

    always_comb begin
        op1_mag = opdata1_i;
        op2_mag = opdata2_i;
        if (signed_div_i && opdata1_i[31]) begin
            op1_mag = ~opdata1_i + 32'd1;
        end
        if (signed_div_i && opdata2_i[31]) begin
            op2_mag = ~opdata2_i + 32'd1;
        end
    end

    // One restoring step. work_q[64:31] is the partial remainder after it has
    // been shifted left by one bit. That value is below 2 * divisor, so it
    // fits in 33 bits. The subtraction is done on 34 bits so that bit 33 acts
    // as the borrow.
    logic [33:0] trial;
    logic [64:0] step_next;

    always_comb begin
        trial = work_q[64:31] - {2'b00, divisor_q};
        if (trial[33]) begin
            // Negative: restore, i.e. keep the shifted value and use quotient bit 0.
            step_next = {work_q[63:0], 1'b0};
        end else begin
            step_next = {trial[32:0], work_q[30:0], 1'b1};
        end
    end

    // Sign correction of the finished magnitudes.
    logic [31:0] quot_fixed;
    logic [31:0] rem_fixed;

    always_comb begin
        quot_fixed = work_q[31:0];
        rem_fixed  = work_q[63:32];
        if (neg_quot_q) begin
            quot_fixed = ~work_q[31:0] + 32'd1;
        end
        if (neg_rem_q) begin
            rem_fixed = ~work_q[63:32] + 32'd1;
        end
    end

    // Next-state logic and datapath control.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        unique case (state_q)
            StFree: begin
                result_d = 64'd0;
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        state_d = StByZero;
                    end else begin
                        state_d    = StOn;
                        cnt_d      = 6'd0;
                        work_d     = {33'd0, op1_mag};
                        divisor_d  = op2_mag;
                        neg_quot_d = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        neg_rem_d  = signed_div_i & opdata1_i[31];
                    end
                end
            end

            StByZero: begin
                if (annul_i) begin
                    state_d  = StFree;
                    result_d = 64'd0;
                    ready_d  = 1'b0;
                end else begin
                    state_d  = StEnd;
                    result_d = 64'd0;
                    ready_d  = 1'b1;
                end
            end

            StOn: begin
                if (annul_i) begin
                    state_d  = StFree;
                    cnt_d    = 6'd0;
                    result_d = 64'd0;
                    ready_d  = 1'b0;
                end else if (cnt_q != NumSteps) begin
                    work_d = step_next;
                    cnt_d  = cnt_q + 6'd1;
                end else begin
                    state_d  = StEnd;
                    result_d = {rem_fixed, quot_fixed};
                    ready_d  = 1'b1;
                end
            end

            StEnd: begin
                // annul_i has no effect here. The result stays until the consumer drops start_i.
                if (!start_i) begin
                    state_d  = StFree;
                    cnt_d    = 6'd0;
                    result_d = 64'd0;
                    ready_d  = 1'b0;
                end
            end

            default: begin
                state_d  = StFree;
                result_d = 64'd0;
                ready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StFree;
            cnt_q      <= 6'd0;
            work_q     <= 65'd0;
            divisor_q  <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= 64'd0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// -----------------------------------------------------------------------------
// tb_div: self-checking bench for div. The bench runs directed scenarios and
// then randomized divisions. Expected results come from a reference model
// that uses plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks   = 0;
    int failures = 0;

    div dut (
        .clk         (clk),
        .rst         (rst),
        .signed_div_i(signed_div_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .start_i     (start_i),
        .annul_i     (annul_i),
        .result_o    (result_o),
        .ready_o     (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 2000000");
        $fatal(1);
    end

    // Reference model. Result is {remainder, quotient}. Division truncates
    // toward zero, and the remainder takes the sign of the dividend.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        longint      sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    task automatic recover();
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;
        rst     = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Runs one full transaction: request, latency, result, optional hold in
    // END (with annul_i pulsed, which must have no effect), then release.
    // Operands are scrambled right after acceptance.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input int hold, input logic [63:0] exp, input string tag);
        int lat;
        int exp_lat;
        bit got;
        @(negedge clk);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = s;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom);
        lat = 0;
        got = 0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (ready_o) got = 1;
        end
        exp_lat = (b == 32'd0) ? 1 : 33;
        checks++;
        if (!got || lat != exp_lat) begin
            failures++;
            $display("FAIL %s_latency: got ready after %0d edges (seen=%0d), required %0d",
                     tag, lat, got, exp_lat);
        end
        if (!got) begin
            recover();
            return;
        end
        checks++;
        if (result_o !== exp) begin
            failures++;
            $display("FAIL %s_result: got %h, required %h", tag, result_o, exp);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            annul_i = (i == 1);
            @(posedge clk);
            #1;
            checks++;
            if (ready_o !== 1'b1 || result_o !== exp) begin
                failures++;
                $display("FAIL %s_hold%0d: got ready=%b result=%h, required ready=1 result=%h",
                         tag, i, ready_o, result_o, exp);
            end
        end
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            failures++;
            $display("FAIL %s_release: got ready=%b result=%h, required ready=0 result=0",
                     tag, ready_o, result_o);
        end
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            failures++;
            $display("FAIL reset_state: got ready=%b result=%h, required ready=0 result=0",
                     ready_o, result_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            failures++;
            $display("FAIL idle_after_reset: got ready=%b result=%h, required 0/0",
                     ready_o, result_o);
        end
    endtask

    task automatic test_unsigned();
        run_div(32'd100, 32'd7, 1'b0, 0, {32'd2, 32'd14}, "udiv_100_7");
        run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, {32'd0, 32'd1}, "udiv_max_max");
        run_div(32'd3, 32'd10, 1'b0, 0, {32'd3, 32'd0}, "udiv_small");
    endtask

    task automatic test_signed();
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "sdiv_m7_2");
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 0, {32'h0000_0001, 32'hFFFF_FFFD}, "sdiv_7_m2");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, {32'd0, 32'h8000_0000}, "sdiv_ovf");
        run_div(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 0,
                model(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1), "sdiv_m100_m7");
    endtask

    task automatic test_div_zero();
        run_div(32'd5, 32'd0, 1'b0, 0, 64'd0, "divzero_u");
        run_div(32'hFFFF_FFFB, 32'd0, 1'b1, 2, 64'd0, "divzero_s");
    endtask

    task automatic test_annul();
        bit seen;
        @(negedge clk);
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd9;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            failures++;
            $display("FAIL annul_on: got ready=%b result=%h, required 0/0", ready_o, result_o);
        end
        @(negedge clk);
        annul_i = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) seen = 1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL annul_stays_idle: got ready=1 after annul, required ready=0");
        end
        run_div(32'd9, 32'd3, 1'b0, 0, {32'd0, 32'd3}, "after_annul");
        @(negedge clk);
        opdata1_i = 32'd5;
        opdata2_i = 32'd0;
        start_i   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            failures++;
            $display("FAIL annul_byzero: got ready=%b result=%h, required 0/0", ready_o, result_o);
        end
        @(negedge clk);
        annul_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit seen;
        int n;
        @(negedge clk);
        opdata1_i    = 32'h1234_5678;
        opdata2_i    = 32'd3;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        #2;
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            failures++;
            $display("FAIL reset_mid_on: got ready=%b result=%h, required 0/0", ready_o, result_o);
        end
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) seen = 1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL reset_mid_idle: got ready=1 after reset, required ready=0");
        end
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0, {32'd0, 32'hFFFF_FFFF}, "after_reset");
        // An asynchronous reset while a result is being held must clear it at once.
        @(negedge clk);
        opdata1_i = 32'd9;
        opdata2_i = 32'd2;
        start_i   = 1'b1;
        n = 0;
        while (!ready_o && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        #2;
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            failures++;
            $display("FAIL reset_in_end: got ready=%b result=%h, required 0/0", ready_o, result_o);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_hold();
        run_div(32'd1000, 32'd33, 1'b0, 5, {32'd10, 32'd30}, "hold5");
        run_div(32'hFFFF_FC18, 32'd33, 1'b1, 5, model(32'hFFFF_FC18, 32'd33, 1'b1), "hold5_s");
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic        s;
        int          sel;
        for (int i = 0; i < 30; i++) begin
            a   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0)      b = 32'd0;
            else if (sel <= 2) b = 32'($urandom_range(1, 20));
            else if (sel == 3) b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            else               b = $urandom;
            if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
            s = 1'($urandom);
            run_div(a, b, s, $urandom_range(0, 2), model(a, b, s), $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_annul();
        test_reset_mid();
        test_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
